// File: rtl/xmt_arbiter_if.sv
// Request/transmit bundle between NUM_REQ byte sources, the round-robin
// arbiter and the transmitter buffer write port.
interface xmt_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: a requester holds req[i] and its byte stable until ack[i]
    // pulses for one cycle; xmt_write is a one-cycle strobe issued only when
    // xmt_ready was seen high, and the buffer drops xmt_ready while busy.
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   lock;
    logic [8*NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   owner;
    logic                 xmt_write;
    logic [7:0]           xmt_data;
    logic                 xmt_ready;

    modport master (
        output req, lock, data_in, xmt_ready,
        input  ack, owner, xmt_write, xmt_data
    );

    modport slave (
        input  req, lock, data_in, xmt_ready,
        output ack, owner, xmt_write, xmt_data
    );
endinterface

// File: rtl/xmt_arbiter.sv
// Round-robin arbiter sharing one transmitter buffer write port among
// NUM_REQ byte sources, with an optional per-requester grant lock.
module xmt_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    xmt_arbiter_if.slave       bus,
    output logic [1:0]         state_o
);
    localparam int          IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned N_U = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 write_q, write_d;
    logic [7:0]           data_q, data_d;

    logic [NUM_REQ-1:0]   owner_eff;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        scan_idx;
    logic                 grant_found;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] base,
                                              input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % N_U;
        return sum[IW-1:0];
    endfunction

    // Candidate search sees the owner as already released when its lock dropped.
    always_comb begin
        owner_eff   = owner_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if ((owner_q != '0) && ((owner_q & bus.lock) == '0)) begin
            owner_eff = '0;
        end
        if (owner_eff != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_eff[i] && bus.req[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = IW'(i);
                end
            end
        end else begin
            // Scan farthest-first so the nearest requester after last wins.
            for (int unsigned k = N_U; k >= 1; k--) begin
                scan_idx = rr_next(last_q, k);
                if (bus.req[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        grant_onehot = NUM_REQ'(1) << grant_idx;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        ack_d   = '0;
        write_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                owner_d = owner_eff;
                if (bus.xmt_ready && grant_found) begin
                    data_d  = bus.data_in[{grant_idx, 3'b000} +: 8];
                    write_d = 1'b1;
                    ack_d   = grant_onehot;
                    last_d  = grant_idx;
                    owner_d = bus.lock[grant_idx] ? grant_onehot : '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Ready may still be high for a cycle after the buffer took the byte.
                if (!bus.xmt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            owner_q <= '0;
            ack_q   <= '0;
            write_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.owner     = owner_q;
    assign bus.xmt_write = write_q;
    assign bus.xmt_data  = data_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_xmt_arbiter.sv
// Bench for xmt_arbiter: directed requester scenarios, a transmitter buffer
// model, and a scoreboard of expected {ack, byte} pairs.
module tb_xmt_arbiter;
    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic [1:0] state;
    int         compared;
    int         mismatched;
    int         busy_cycles;
    int         busy_cnt;
    logic [11:0] exp_q[$];

    xmt_arbiter_if #(.NUM_REQ(N)) bus ();

    xmt_arbiter #(.NUM_REQ(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [3:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    // Monitor / scoreboard plus transmitter buffer model
    always @(negedge clk) begin
        if (reset) begin
            bus.xmt_ready = 1'b1;
            busy_cnt      = 0;
        end else begin
            if (bus.xmt_write) begin
                check("ready_at_write", {31'd0, bus.xmt_ready}, 32'd1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got ack=%b data=%0h expected none",
                             bus.ack, bus.xmt_data);
                end else begin
                    check("grant", {20'd0, bus.ack, bus.xmt_data}, {20'd0, exp_q.pop_front()});
                end
                bus.xmt_ready = 1'b0;
                busy_cnt      = busy_cycles;
            end else begin
                if (bus.ack != '0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL ack_without_write: got ack=%b expected 0", bus.ack);
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) bus.xmt_ready = 1'b1;
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_write(output logic [3:0] a);
        int n;
        n = 0;
        a = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.xmt_write && n < 200);
        if (bus.xmt_write) begin
            a = bus.ack;
        end else begin
            compared++;
            mismatched++;
            $display("FAIL write_timeout: got no xmt_write in %0d cycles expected one", n);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.req     = '0;
        bus.lock    = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        int cnt[N];
        int sent;
        compared    = 0;
        mismatched  = 0;
        busy_cycles = 2;
        busy_cnt    = 0;
        bus.xmt_ready = 1'b1;
        reset = 1'b1;
        bus.req = '0;
        bus.lock = '0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_write", {31'd0, bus.xmt_write}, 32'd0);
        check("rst_data", {24'd0, bus.xmt_data}, 32'h00);
        check("rst_ack", {28'd0, bus.ack}, 32'd0);
        check("rst_owner", {28'd0, bus.owner}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single byte, one-cycle latency and one-cycle strobe
        exp_q.push_back(mk(4'b0001, 8'h41));
        bus.data_in[7:0] = 8'h41;
        bus.req = 4'b0001;
        @(negedge clk);
        check("t1_latency_write", {31'd0, bus.xmt_write}, 32'd1);
        check("t1_data", {24'd0, bus.xmt_data}, 32'h41);
        check("t1_ack", {28'd0, bus.ack}, 32'b0001);
        bus.req = '0;
        @(negedge clk);
        check("t1_write_pulse", {31'd0, bus.xmt_write}, 32'd0);
        check("t1_ack_pulse", {28'd0, bus.ack}, 32'd0);
        repeat (4) @(negedge clk);

        // All four requesting: order 0,1,2,3,0 from reset priority
        do_reset();
        bus.data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        exp_q.push_back(mk(4'b0001, 8'h10));
        exp_q.push_back(mk(4'b0010, 8'h11));
        exp_q.push_back(mk(4'b0100, 8'h12));
        exp_q.push_back(mk(4'b1000, 8'h13));
        exp_q.push_back(mk(4'b0001, 8'h10));
        bus.req = 4'b1111;
        repeat (5) wait_write(a);
        bus.req = '0;
        repeat (4) @(negedge clk);

        // last=1, then req 0101: requester 2 before 0
        exp_q.push_back(mk(4'b0010, 8'h21));
        bus.data_in[15:8] = 8'h21;
        bus.req = 4'b0010;
        wait_write(a);
        bus.req = '0;
        repeat (4) @(negedge clk);
        exp_q.push_back(mk(4'b0100, 8'h32));
        exp_q.push_back(mk(4'b0001, 8'h30));
        bus.data_in[7:0]   = 8'h30;
        bus.data_in[23:16] = 8'h32;
        bus.req = 4'b0101;
        wait_write(a);
        bus.req[2] = 1'b0;
        wait_write(a);
        bus.req = '0;
        repeat (4) @(negedge clk);

        // Lock: three bytes of requester 1 back-to-back, then 0 after release
        exp_q.push_back(mk(4'b0010, 8'h51));
        exp_q.push_back(mk(4'b0010, 8'h52));
        exp_q.push_back(mk(4'b0010, 8'h53));
        exp_q.push_back(mk(4'b0001, 8'h40));
        bus.data_in[7:0]  = 8'h40;
        bus.data_in[15:8] = 8'h51;
        bus.lock = 4'b0010;
        bus.req  = 4'b0011;
        wait_write(a);
        check("t4_owner_locked", {28'd0, bus.owner}, 32'b0010);
        bus.data_in[15:8] = 8'h52;
        wait_write(a);
        bus.data_in[15:8] = 8'h53;
        wait_write(a);
        check("t4_owner_still", {28'd0, bus.owner}, 32'b0010);
        bus.lock = '0;
        wait_write(a);
        check("t4_owner_released", {28'd0, bus.owner}, 32'd0);
        bus.req = '0;
        repeat (4) @(negedge clk);

        // Slow buffer: 20 bytes, five per requester, order starts at 1
        busy_cycles = 10;
        for (int n = 0; n < 20; n++) begin
            int i;
            i = (n + 1) % N;
            exp_q.push_back(mk(4'(1 << i), 8'h80 | 8'(i << 4) | 8'(n / 4)));
        end
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            bus.data_in[8*i +: 8] = 8'h80 | 8'(i << 4);
        end
        bus.req = 4'b1111;
        sent = 0;
        while (sent < 20) begin
            wait_write(a);
            if (a == '0) break;
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 5) bus.req[i] = 1'b0;
                    else bus.data_in[8*i +: 8] = 8'h80 | 8'(i << 4) | 8'(cnt[i]);
                end
            end
            sent++;
        end
        bus.req = '0;
        busy_cycles = 2;
        repeat (15) @(negedge clk);

        // Reset while in WRITE: outputs clear at once, priority back to 0
        exp_q.push_back(mk(4'b0001, 8'h66));
        bus.data_in[7:0] = 8'h66;
        bus.req = 4'b0001;
        wait_write(a);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_write", {31'd0, bus.xmt_write}, 32'd0);
        check("t6_rst_ack", {28'd0, bus.ack}, 32'd0);
        check("t6_rst_state", {30'd0, state}, 32'd0);
        check("t6_rst_data", {24'd0, bus.xmt_data}, 32'h00);
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(mk(4'b0001, 8'h70));
        exp_q.push_back(mk(4'b0010, 8'h71));
        bus.data_in[7:0]  = 8'h70;
        bus.data_in[15:8] = 8'h71;
        bus.req = 4'b0011;
        wait_write(a);
        bus.req[0] = 1'b0;
        wait_write(a);
        bus.req = '0;
        repeat (10) @(negedge clk);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
